// File: rtl/nor_gate_tester.sv
// nor_gate_tester
//
// Clocked self-test sequencer for quad-NOR (HC02-class) logic. A run walks
// the four NOR input combinations in Gray order (00, 10, 11, 01). Each vector
// is driven onto every gate channel and held for SETTLE cycles. The returned
// outputs are then sampled once and compared with the NOR expectation.
// Mismatches accumulate into a per-channel failure mask and a saturating
// error count. At the end of the run a one-cycle done pulse is issued and
// pass is latched until the next start.
//
// Parameters:
//   CH       number of gate channels (1..16)
//   SETTLE   cycles each vector is held before sampling (>= 1)
//   ERRW     width of err_count
//   STAGGER  0: every channel gets the same vector
//            1: channel k gets vector (idx+k) mod 4, exposing inter-channel shorts
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin a run (only honoured while idle)
//   a_out      A input of each DUT channel
//   b_out      B input of each DUT channel
//   y_in       DUT outputs, already synchronous to clk
//   busy       run in progress (APPLY or SAMPLE)
//   done       one-cycle pulse when a run completes
//   pass       last completed run saw no mismatches; held until next start
//   err_count  total mismatched channel-samples, saturating
//   fail_mask  bit k set if channel k mismatched at least once
module nor_gate_tester #(
    parameter int CH      = 4,
    parameter int SETTLE  = 5,
    parameter int ERRW    = 8,
    parameter int STAGGER = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [CH-1:0]   a_out,
    output logic [CH-1:0]   b_out,
    input  logic [CH-1:0]   y_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_count,
    output logic [CH-1:0]   fail_mask
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_APPLY  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SETTLE - 1);

    // The sum needs headroom for the current count plus up to 16 new
    // mismatches before it is clamped back into ERRW bits.
    localparam int SUMW = ERRW + 6;
    localparam logic [ERRW-1:0] ERR_MAX = '1;

    logic [1:0]      state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CH-1:0]   a_q, a_d;
    logic [CH-1:0]   b_q, b_d;
    logic [ERRW-1:0] err_q, err_d;
    logic [CH-1:0]   mask_q, mask_d;
    logic            pass_q, pass_d;

    logic [CH-1:0]   mismatch;
    logic [SUMW-1:0] popCount;
    logic [SUMW-1:0] errSum;

    // Compare against the vector currently on the pins. a_q/b_q are held
    // through SAMPLE, so this is always the settled vector.
    always_comb begin
        mismatch = y_in ^ ~(a_q | b_q);
        popCount = '0;
        for (int k = 0; k < CH; k++) begin
            popCount = popCount + SUMW'(mismatch[k]);
        end
        errSum = SUMW'(err_q) + popCount;
    end

    // Sequencer: IDLE waits for start, APPLY holds a vector for SETTLE
    // cycles, SAMPLE scores it, FINISH publishes the result for one cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mask_d  = mask_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_APPLY;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    err_d   = '0;
                    mask_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            ST_APPLY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                mask_d = mask_q | mismatch;
                if (errSum > SUMW'(ERR_MAX)) begin
                    err_d = ERR_MAX;
                end else begin
                    err_d = errSum[ERRW-1:0];
                end
                if (idx_q == 2'd3) begin
                    state_d = ST_FINISH;
                    // pass must include the score of this last sample.
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = ST_APPLY;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin drive is derived from the next state so the first vector appears
    // on the same edge that accepts start. Vector table in Gray order:
    // idx 0=(0,0) 1=(1,0) 2=(1,1) 3=(0,1), i.e. a = idx[1]^idx[0], b = idx[1].
    always_comb begin
        logic [1:0] vecIdx;
        a_d    = '0;
        b_d    = '0;
        vecIdx = 2'd0;
        if (state_d == ST_APPLY || state_d == ST_SAMPLE) begin
            for (int k = 0; k < CH; k++) begin
                if (STAGGER != 0) begin
                    vecIdx = idx_d + 2'(k);
                end else begin
                    vecIdx = idx_d;
                end
                a_d[k] = vecIdx[1] ^ vecIdx[0];
                b_d[k] = vecIdx[1];
            end
        end
    end

    // State registers; reset discards any partial run without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= '0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = (state_q == ST_APPLY) || (state_q == ST_SAMPLE);
    assign done      = (state_q == ST_FINISH);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_mask = mask_q;

endmodule
